// File: rtl/mp85_bus_target.sv
// mp85_bus_target: CPU bus expansion-RAM target.
// Decodes a 2^ADDR_BITS-byte window at BASE_ADDR. Serves byte reads and writes
// from local RAM after WAIT_STATES wait cycles, and signals completion with a
// one-cycle ready pulse.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | no cycle owned; accept a hit with exactly one strobe high
// WAIT    | counting wait states; abort if the latched strobe drops
// ACCESS  | one cycle: read RAM into data_out or write latched data
// RELEASE | ready already pulsed; hold selected until both strobes drop
module mp85_bus_target #(
    parameter logic [15:0] BASE_ADDR   = 16'h8000,
    parameter int          ADDR_BITS   = 8,
    parameter int          WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] address,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [7:0]  data_in,
    output logic [7:0]  data_out,
    output logic        ready,
    output logic        selected,
    output logic        err
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACCESS,
        ST_RELEASE
    } state_t;

    state_t               state;
    logic [3:0]           cnt;
    logic [ADDR_BITS-1:0] off;
    logic                 op_wr;
    logic [7:0]           wdata;
    logic [7:0]           mem [2**ADDR_BITS];

    logic hit;
    logic one_strobe;
    logic both_strobes;
    logic strobe_held;

    // Window decode and strobe classification for the current bus cycle.
    always_comb begin
        hit          = (address[15:ADDR_BITS] == BASE_ADDR[15:ADDR_BITS]);
        one_strobe   = mem_read ^ mem_write;
        both_strobes = mem_read & mem_write;
        strobe_held  = op_wr ? mem_write : mem_read;
    end

    // Bus-cycle sequencer; all outputs are registered here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            cnt      <= 4'd0;
            off      <= '0;
            op_wr    <= 1'b0;
            wdata    <= 8'h00;
            data_out <= 8'h00;
            ready    <= 1'b0;
            selected <= 1'b0;
            err      <= 1'b0;
        end else begin
            ready <= 1'b0;
            err   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (hit && both_strobes) begin
                        err <= 1'b1;
                    end else if (hit && one_strobe) begin
                        off      <= address[ADDR_BITS-1:0];
                        op_wr    <= mem_write;
                        wdata    <= data_in;
                        selected <= 1'b1;
                        cnt      <= 4'(WAIT_STATES);
                        state    <= (WAIT_STATES == 0) ? ST_ACCESS : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // Abort takes priority over finishing the wait.
                    if (!strobe_held) begin
                        selected <= 1'b0;
                        cnt      <= 4'd0;
                        state    <= ST_IDLE;
                    end else if (cnt <= 4'd1) begin
                        cnt   <= 4'd0;
                        state <= ST_ACCESS;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                ST_ACCESS: begin
                    if (!op_wr) begin
                        data_out <= mem[off];
                    end
                    ready <= 1'b1;
                    state <= ST_RELEASE;
                end
                ST_RELEASE: begin
                    if (!mem_read && !mem_write) begin
                        selected <= 1'b0;
                        state    <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // RAM write port; contents survive reset, and a reset before ACCESS drops the write.
    always_ff @(posedge clk) begin
        if (state == ST_ACCESS && op_wr) begin
            mem[off] <= wdata;
        end
    end

endmodule

// File: tb/tb_mp85_bus_target.sv
// Directed bench for mp85_bus_target: table of single accesses plus hand
// sequences for out-of-window, illegal, abort, held-strobe and reset cases.
module tb_mp85_bus_target;

    logic        clk = 1'b0;
    logic        rst = 1'b0;

    logic [15:0] address = 16'h0000;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [7:0]  data_in = 8'h00;
    logic [7:0]  data_out;
    logic        ready, selected, err;

    logic [15:0] address0 = 16'h0000;
    logic        mem_read0 = 1'b0;
    logic        mem_write0 = 1'b0;
    logic [7:0]  data_in0 = 8'h00;
    logic [7:0]  data_out0;
    logic        ready0, selected0, err0;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mp85_bus_target #(.BASE_ADDR(16'h8000), .ADDR_BITS(8), .WAIT_STATES(2)) dut (
        .clk(clk), .rst(rst), .address(address), .mem_read(mem_read),
        .mem_write(mem_write), .data_in(data_in), .data_out(data_out),
        .ready(ready), .selected(selected), .err(err)
    );

    mp85_bus_target #(.BASE_ADDR(16'h8000), .ADDR_BITS(8), .WAIT_STATES(0)) dut0 (
        .clk(clk), .rst(rst), .address(address0), .mem_read(mem_read0),
        .mem_write(mem_write0), .data_in(data_in0), .data_out(data_out0),
        .ready(ready0), .selected(selected0), .err(err0)
    );

    typedef struct {
        bit          wr;
        logic [15:0] a;
        logic [7:0]  d;
        logic [7:0]  exp;
        int          hold;
    } vec_t;

    vec_t tbl[8];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic rdy(input int which);
        return (which == 0) ? ready : ready0;
    endfunction

    function automatic logic sel(input int which);
        return (which == 0) ? selected : selected0;
    endfunction

    function automatic logic [7:0] dout(input int which);
        return (which == 0) ? data_out : data_out0;
    endfunction

    task automatic drive(input int which, input logic rd, input logic wr,
                         input logic [15:0] a, input logic [7:0] d);
        if (which == 0) begin
            address = a; mem_read = rd; mem_write = wr; data_in = d;
        end else begin
            address0 = a; mem_read0 = rd; mem_write0 = wr; data_in0 = d;
        end
    endtask

    // One complete access: accept, latency, pulse width, optional hold, release.
    task automatic access(input int which, input bit wr, input logic [15:0] a,
                          input logic [7:0] d, input logic [7:0] exp, input int hold,
                          input string nm);
        int lat;
        int extra;
        int want;
        want = (which == 0) ? 4 : 2;
        lat = 0;
        extra = 0;
        drive(which, !wr, wr, a, d);
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (i == 1) check({nm, " selected_at_accept"}, 32'(sel(which)), 32'd1);
            if (rdy(which)) begin
                lat = i;
                break;
            end
        end
        check({nm, " ready_latency"}, 32'(lat), 32'(want));
        if (!wr) check({nm, " read_data"}, 32'(dout(which)), 32'(exp));
        tick();
        check({nm, " ready_width"}, 32'(rdy(which)), 32'd0);
        for (int h = 0; h < hold; h++) begin
            tick();
            if (rdy(which)) extra++;
        end
        if (hold > 0) begin
            check({nm, " no_second_ready"}, 32'(extra), 32'd0);
            check({nm, " data_held"}, 32'(dout(which)), 32'(exp));
        end
        check({nm, " selected_before_release"}, 32'(sel(which)), 32'd1);
        drive(which, 1'b0, 1'b0, a, d);
        tick();
        check({nm, " selected_after_release"}, 32'(sel(which)), 32'd0);
    endtask

    initial begin
        int bad;

        tbl[0] = '{wr: 1'b1, a: 16'h8010, d: 8'hA5, exp: 8'h00, hold: 0};
        tbl[1] = '{wr: 1'b0, a: 16'h8010, d: 8'h00, exp: 8'hA5, hold: 0};
        tbl[2] = '{wr: 1'b1, a: 16'h80FF, d: 8'h5A, exp: 8'h00, hold: 0};
        tbl[3] = '{wr: 1'b0, a: 16'h80FF, d: 8'h00, exp: 8'h5A, hold: 10};
        tbl[4] = '{wr: 1'b1, a: 16'h8020, d: 8'h77, exp: 8'h00, hold: 0};
        tbl[5] = '{wr: 1'b1, a: 16'h8005, d: 8'h00, exp: 8'h00, hold: 0};
        tbl[6] = '{wr: 1'b0, a: 16'h8020, d: 8'h00, exp: 8'h77, hold: 0};
        tbl[7] = '{wr: 1'b0, a: 16'h8005, d: 8'h00, exp: 8'h00, hold: 0};

        // Reset state
        #2 rst = 1'b1;
        #1;
        check("reset data_out", 32'(data_out), 32'h00);
        check("reset ready", 32'(ready), 32'd0);
        check("reset selected", 32'(selected), 32'd0);
        check("reset err", 32'(err), 32'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        for (int k = 0; k < 8; k++) begin
            access(0, tbl[k].wr, tbl[k].a, tbl[k].d, tbl[k].exp, tbl[k].hold,
                   $sformatf("vec%0d", k));
        end

        // Out-of-window reads and writes are ignored
        bad = 0;
        drive(0, 1'b1, 1'b0, 16'h7FFF, 8'h00);
        for (int i = 0; i < 10; i++) begin
            tick();
            if (ready || selected || err) bad++;
        end
        drive(0, 1'b1, 1'b0, 16'h9000, 8'h00);
        for (int i = 0; i < 10; i++) begin
            tick();
            if (ready || selected || err) bad++;
        end
        check("oow read quiet cycles", 32'(bad), 32'd0);
        bad = 0;
        drive(0, 1'b0, 1'b1, 16'h9010, 8'hEE);
        for (int i = 0; i < 6; i++) begin
            tick();
            if (ready || selected || err) bad++;
        end
        drive(0, 1'b0, 1'b1, 16'h7F10, 8'hEE);
        for (int i = 0; i < 6; i++) begin
            tick();
            if (ready || selected || err) bad++;
        end
        check("oow write quiet cycles", 32'(bad), 32'd0);
        drive(0, 1'b0, 1'b0, 16'h0000, 8'h00);
        tick();
        access(0, 1'b0, 16'h8010, 8'h00, 8'hA5, 0, "oow no_ram_change");

        // Both strobes: err every cycle, no access
        drive(0, 1'b1, 1'b1, 16'h8000, 8'h99);
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("both err c%0d", i), 32'(err), 32'd1);
            check($sformatf("both no_ready c%0d", i), 32'(ready | selected), 32'd0);
        end
        drive(0, 1'b0, 1'b0, 16'h8000, 8'h00);
        tick();
        check("both err_clears", 32'(err), 32'd0);
        access(0, 1'b1, 16'h8000, 8'h3C, 8'h00, 0, "after_err write");
        access(0, 1'b0, 16'h8000, 8'h00, 8'h3C, 0, "after_err read");

        // Abort a write during WAIT
        drive(0, 1'b0, 1'b1, 16'h8020, 8'hFF);
        tick();
        tick();
        drive(0, 1'b0, 1'b0, 16'h8020, 8'hFF);
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (ready) bad++;
        end
        check("abort no_ready", 32'(bad), 32'd0);
        check("abort selected_low", 32'(selected), 32'd0);
        access(0, 1'b0, 16'h8020, 8'h00, 8'h77, 0, "abort readback");

        // Zero-wait-state build
        access(1, 1'b1, 16'h8001, 8'h42, 8'h00, 0, "ws0 write");
        access(1, 1'b0, 16'h8001, 8'h00, 8'h42, 3, "ws0 read");

        // Reset during WAIT of a write drops the write
        drive(0, 1'b0, 1'b1, 16'h8005, 8'h11);
        tick();
        check("rst_mid selected_before", 32'(selected), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("rst_mid selected", 32'(selected), 32'd0);
        check("rst_mid ready", 32'(ready), 32'd0);
        check("rst_mid data_out", 32'(data_out), 32'h00);
        rst = 1'b0;
        drive(0, 1'b0, 1'b0, 16'h8005, 8'h00);
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (ready || selected) bad++;
        end
        check("rst_mid quiet", 32'(bad), 32'd0);
        access(0, 1'b0, 16'h8005, 8'h00, 8'h00, 0, "rst_mid readback");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mp85_bus_target.md
Name: mp85_bus_target

Overview:
- Memory-mapped bus responder: the slave end of the CPU memory interface (address, mem_read, mem_write, data).
- Decodes an address window and serves byte reads and writes from local RAM.
- Inserts a programmable number of wait states and signals completion with a one-cycle ready pulse.
- Sits beside the main memory on the CPU bus as an expansion RAM/peripheral target.

Parameters:
- BASE_ADDR, 16'h8000, first address of the decoded window (aligned to 2^ADDR_BITS).
- ADDR_BITS, 8, window and RAM size is 2^ADDR_BITS bytes.
- WAIT_STATES, 2, cycles inserted between accept and ready (0..15).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- address  in  16  bus address from initiator.
- mem_read  in  1  read strobe, held until ready.
- mem_write  in  1  write strobe, held until ready.
- data_in  in  8  write data from initiator, sampled at accept.
- data_out  out  8  read data, valid from the ready cycle and held until the next read completes.
- ready  out  1  one-cycle completion pulse.
- selected  out  1  high while this target owns the current bus cycle.
- err  out  1  one-cycle pulse on an illegal request.

Behaviour:
- Reset (async): state IDLE, data_out=8'h00, ready=0, selected=0, err=0, wait counter=0. RAM contents are not reset.
- hit = address[15:ADDR_BITS] == BASE_ADDR[15:ADDR_BITS]. The offset is address[ADDR_BITS-1:0]; no wrap beyond the window.
- FSM states: IDLE, WAIT, ACCESS, RELEASE. All outputs are registered.
- IDLE, hit and exactly one strobe high:
  - Accept at edge E0.
  - Latch offset, op and data_in.
  - selected<=1.
  - Counter<=WAIT_STATES.
  - Go to WAIT, or to ACCESS if WAIT_STATES==0.
- IDLE, hit and both strobes high: err pulses for 1 cycle, no access, stay IDLE. Re-evaluate next cycle; err repeats each cycle both strobes remain high.
- IDLE, no hit: ignore the request; ready, selected and err stay 0.
- WAIT: counter decrements each cycle; at 1, go to ACCESS.
- Abort: if the latched strobe drops during WAIT, return to IDLE, selected<=0, no write, no ready.
- ACCESS, one cycle:
  - Read: data_out<=RAM[offset].
  - Write: RAM[offset]<=latched data.
  - ready<=1 (visible the following cycle).
  - Go to RELEASE.
- Latency: ready is high during exactly one cycle, the cycle after edge E0+WAIT_STATES+1. With WAIT_STATES=2, ready is high in the 4th cycle after accept.
- RELEASE: ready<=0; stay until mem_read==0 and mem_write==0, then selected<=0 and go to IDLE. A strobe held high never causes a second access.
- Address changes after accept are ignored (the latched offset is used).
- Reset asserted mid-operation: immediate return to IDLE, pending write dropped, ready and selected forced to 0.
- Accesses are strictly one at a time; a new request is only accepted in IDLE.

Test Plan:
1. WAIT_STATES=2, write 8'hA5 to 16'h8010, hold until ready, drop strobe; then read 16'h8010 -> ready high exactly 1 cycle, 4 cycles after each accept; data_out=8'hA5; selected falls one cycle after strobe low.
2. Read 16'h7FFF and 16'h9000 (out of window) -> ready, selected and err stay 0 for 20 cycles; no RAM change.
3. Both strobes high at 16'h8000 for 3 cycles -> err high 3 cycles, no ready; then write 8'h3C to 16'h8000 and read back 8'h3C.
4. Write 8'hFF to 16'h8020, drop strobe after 1 wait cycle (abort); then read 16'h8020 -> previous content returned, no ready during the aborted cycle.
5. Hold mem_read high for 10 cycles after ready at 16'h80FF -> exactly one ready pulse; WAIT_STATES=0 build gives ready 2 cycles after accept.
6. Assert rst in WAIT of a write of 8'h11 to 16'h8005 -> outputs reset immediately; subsequent read of 16'h8005 does not return 8'h11 (pre-loaded 8'h00 earlier).
